// File: rtl/mmio_uart_pkg.sv
//==============================================================================
// mmio_uart_pkg : shared types and register map for the MMIO UART transmitter
// Revision 1.0
//==============================================================================
`default_nettype none

package mmio_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [2:0] OFS_DATA   = 3'h0;
  localparam logic [2:0] OFS_STATUS = 3'h4;

  localparam int unsigned BUSY    = 0;
  localparam int unsigned FULL    = 1;
  localparam int unsigned EMPTY   = 2;
  localparam int unsigned OVF     = 3;
  localparam int unsigned CNT_LSB = 4;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
//==============================================================================
// sync_fifo : power-of-two synchronous FIFO; a push while full is accepted
//             only when a pop happens on the same edge. Revision 1.0
//==============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
//==============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with TX FIFO; defining
//                UART_TX_PARITY_EN adds an even-parity bit. Revision 1.0
//==============================================================================
`default_nettype none

module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        txd
);

  localparam int             BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam int             CW       = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          is_status, bit_end;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel         = (a[31:3] == BASE_ADDR[31:3]);
  assign is_status   = (a[2] == OFS_STATUS[2]);
  assign fifo_push   = we && sel && !is_status;
  assign bit_end     = (baud_q == BAUD_MAX);
  assign txd         = txd_q;
  assign unused_bits = ^{wd[31:8], a[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (wd[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status               = '0;
    status[BUSY]         = (state_q != S_IDLE);
    status[FULL]         = fifo_full;
    status[EMPTY]        = fifo_empty;
    status[OVF]          = ovf_q;
    status[CNT_LSB +: 3] = 3'(fifo_count);
    rd = (sel && is_status) ? status : '0;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;

    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = S_START;
          txd_d    = 1'b0;
          baud_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
            txd_d = shift_q[idx_q + 3'd1];
          end else begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = even_parity(shift_q);
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end
        end
      end
      S_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
`else
        state_d = S_IDLE;
        txd_d   = 1'b1;
`endif
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = S_START;
            txd_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    else if (we && sel && is_status)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
//==============================================================================
// tb_mmio_uart_tx : randomized scoreboard bench for mmio_uart_tx
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0080;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [31:0] a     = 32'h0;
  logic [31:0] wd    = 32'h0;
  logic [31:0] rd;
  logic        sel;
  logic        txd;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus remaining-cycles counter for the frame on the wire.
  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_fifo[$];
  int         m_rem = 0;
  bit         m_ovf = 1'b0;
  int         cyc   = 0;
  int         m_pre;
  bit         m_pop, m_win;
  exp_t       m_e;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      m_pre = m_fifo.size();
      m_pop = 1'b0;
      if (m_rem <= 1) begin
        m_pop = (m_pre > 0);
        m_rem = m_pop ? FRAME : 0;
      end else begin
        m_rem--;
      end
      if (m_pop) begin
        m_e.b = m_fifo.pop_front();
        m_e.t = cyc;
        exp_q.push_back(m_e);
      end
      m_win = we && ((a >> 3) == (BASE >> 3));
      if (m_win && !a[2]) begin
        if (m_pre < DEPTH || m_pop) m_fifo.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end
      if (m_win && a[2]) m_ovf = 1'b0;
    end
  end

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int          n;
    n    = m_fifo.size();
    s    = '0;
    s[0] = (m_rem != 0);
    s[1] = (n == DEPTH);
    s[2] = (n == 0);
    s[3] = m_ovf;
    s[6:4] = 3'(n);
    return s;
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor: receives frames off txd and scores them against the model's queue.
  bit   in_frame = 1'b0;
  int   k        = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && txd !== 1'b1) begin
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          k        = 0;
          chk("start_cycle", cyc, cur.t);
        end
      end
      if (in_frame) begin
        chk($sformatf("txd_byte%02h_bit%0d", cur.b, k / CPB), 32'(txd), 32'(exp_bit(cur.b, k / CPB)));
        k++;
        if (k == FRAME) in_frame = 1'b0;
      end
    end
  end

  task automatic bus(input logic w, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = w;
    a  = addr;
    wd = data;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd_status(input string name, output logic [31:0] v);
    @(negedge clk);
    we = 1'b0;
    a  = BASE + 32'd4;
    wd = 32'h0;
    #1;
    chk(name, rd, m_status());
    v = rd;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || m_rem != 0 || in_frame) && n < limit) begin
      idle(1);
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 32'd1);
    idle(2);
  endtask

  logic [31:0] st;
  logic [31:0] addr;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_txd", 32'(txd), 32'd1);
    rd_status("reset_status_model", st);
    chk("reset_status", st, 32'h4);

    // Single frame of 0xA5
    bus(1'b1, BASE, 32'hA5);
    idle(6);
    rd_status("busy_during_frame", st);
    chk("busy_bit", 32'(st[0]), 32'd1);
    drain(200);
    rd_status("after_frame", st);
    chk("idle_status", st, 32'h4);

    // Three back-to-back frames
    bus(1'b1, BASE, 32'h11);
    bus(1'b1, BASE, 32'h22);
    bus(1'b1, BASE, 32'h33);
    rd_status("count_after_three", st);
    chk("count_is_2", 32'(st[6:4]), 32'd2);
    drain(400);

    // Overflow: six writes while idle
    for (int i = 0; i < 6; i++) bus(1'b1, BASE, 32'($urandom_range(0, 255)));
    rd_status("overflow_status", st);
    chk("ovf_set", 32'(st[3]), 32'd1);
    chk("full_set", 32'(st[1]), 32'd1);
    bus(1'b1, BASE + 32'd4, 32'hFF);
    rd_status("ovf_cleared_status", st);
    chk("ovf_cleared", 32'(st[3]), 32'd0);
    drain(600);

    // STATUS write and DATA read send nothing; window decode
    bus(1'b1, BASE + 32'd4, 32'h55);
    @(negedge clk);
    we = 1'b0;
    a  = BASE;
    #1;
    chk("rd_data_zero", rd, 32'h0);
    for (int i = -4; i < 12; i++) begin
      addr = BASE + 32'(i);
      a    = addr;
      #1;
      chk($sformatf("sel_%0h", addr), 32'(sel), 32'((i >= 0) && (i < 8)));
      if (!((i >= 0) && (i < 8))) chk($sformatf("rd_out_%0h", addr), rd, 32'h0);
    end
    idle(3 * FRAME);
    rd_status("no_frame_status", st);

    // Reset mid-frame with bytes queued
    bus(1'b1, BASE, 32'hC3);
    bus(1'b1, BASE, 32'h3C);
    bus(1'b1, BASE, 32'h5A);
    idle(8);
    @(negedge clk);
    reset = 1'b1;
    we    = 1'b0;
    #1;
    chk("reset_txd_immediate", 32'(txd), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_status("post_reset_status_model", st);
    chk("post_reset_status", st, 32'h4);
    idle(3 * FRAME);
    rd_status("post_reset_quiet", st);

`ifdef UART_TX_PARITY_EN
    bus(1'b1, BASE, 32'h07);
    drain(200);
`endif

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: bus(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
        6:                bus(1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
        7:                rd_status("rand_status", st);
        8:                idle($urandom_range(1, 60));
        default:          bus(1'b1, ($urandom_range(0, 1) != 0) ? BASE + 32'd8 : BASE - 32'd4, $urandom);
      endcase
    end
    idle(1);
    rd_status("rand_final_status", st);
    drain(1000);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    rd_status("end_status", st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
